// File: rtl/obuf_arb.sv
// rtl/obuf_arb.sv - mesh router output stage: round-robin arbiter feeding a small output FIFO
// Optional OBUF_PERF_EN adds saturating pkt_cnt / stall_cnt performance counters.

`ifndef PKT_W
`define PKT_W 32
`endif

module obuf_arb #(
  parameter int PYLD_W = `PKT_W,
  parameter int DEPTH  = 2,
  parameter int NPORT  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NPORT-1:0]        arb_req,
  input  logic [NPORT*PYLD_W-1:0] payload_i,
  output logic [NPORT-1:0]        arb_gnt,
  output logic                    obuf_rdy,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [PYLD_W-1:0]       payload_o
`ifdef OBUF_PERF_EN
  ,
  output logic [15:0]             pkt_cnt,
  output logic [15:0]             stall_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int RR_W  = $clog2(NPORT);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [RR_W-1:0]   rr_ptr;
  logic [PYLD_W-1:0] mem [DEPTH];

  logic [NPORT-1:0]  pick;
  logic [RR_W-1:0]   pick_idx;
  logic [PYLD_W-1:0] pick_payload;
  logic              pick_found;
  logic              push, pop;

  // Rotating priority scan starting at rr_ptr; first requester wins.
  always_comb begin
    pick         = '0;
    pick_idx     = '0;
    pick_payload = '0;
    pick_found   = 1'b0;
    for (int k = 0; k < NPORT; k++) begin
      int scan;
      scan = (int'(rr_ptr) + k) % NPORT;
      if (!pick_found && arb_req[scan]) begin
        pick_found   = 1'b1;
        pick[scan]   = 1'b1;
        pick_idx     = RR_W'(scan);
        pick_payload = payload_i[scan*PYLD_W +: PYLD_W];
      end
    end
  end

  // Readiness comes only from registered count, keeping arb_req/out_rdy off this path.
  assign obuf_rdy  = (count != CNT_W'(DEPTH));
  assign arb_gnt   = pick & {NPORT{obuf_rdy}};
  assign push      = |arb_gnt;
  assign out_vld   = (count != '0);
  assign pop       = out_vld & out_rdy;
  assign payload_o = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= pick_payload;
        wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        rr_ptr      <= (pick_idx == RR_W'(NPORT - 1)) ? '0 : pick_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

`ifdef OBUF_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (pop && pkt_cnt != 16'hFFFF) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
      if (out_vld && !out_rdy && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_obuf_arb.sv
// tb/tb_obuf_arb.sv - directed self-checking bench for obuf_arb
// Perf counter scenario is compiled only when OBUF_PERF_EN is defined.

module tb_obuf_arb;

  localparam int PW = 8;
  localparam int DP = 2;
  localparam int NP = 5;

  logic             clk;
  logic             rst_n;
  logic [NP-1:0]    arb_req;
  logic [NP*PW-1:0] payload_i;
  logic [NP-1:0]    arb_gnt;
  logic             obuf_rdy;
  logic             out_vld;
  logic             out_rdy;
  logic [PW-1:0]    payload_o;
`ifdef OBUF_PERF_EN
  logic [15:0]      pkt_cnt;
  logic [15:0]      stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  obuf_arb #(.PYLD_W(PW), .DEPTH(DP), .NPORT(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_req   (arb_req),
    .payload_i (payload_i),
    .arb_gnt   (arb_gnt),
    .obuf_rdy  (obuf_rdy),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .payload_o (payload_o)
`ifdef OBUF_PERF_EN
    ,
    .pkt_cnt   (pkt_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pl(input int idx, input logic [PW-1:0] val);
    payload_i[idx*PW +: PW] = val;
  endtask

  task automatic pulse_reset();
    arb_req = '0;
    rst_n   = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arb_req = '0; out_rdy = 1'b0; payload_i = '0;
    #3;
    checks++; if (arb_gnt !== 5'b00000) begin errors++; $display("FAIL rst_gnt: got %b want 00000", arb_gnt); end
    checks++; if (obuf_rdy !== 1'b1) begin errors++; $display("FAIL rst_obuf_rdy: got %b want 1", obuf_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_out_vld: got %b want 0", out_vld); end
    checks++; if (payload_o !== 8'h00) begin errors++; $display("FAIL rst_payload: got %h want 00", payload_o); end
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (arb_gnt !== 5'b00000) begin errors++; $display("FAIL idle_gnt: got %b want 00000", arb_gnt); end
    checks++; if (obuf_rdy !== 1'b1) begin errors++; $display("FAIL idle_obuf_rdy: got %b want 1", obuf_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL idle_out_vld: got %b want 0", out_vld); end
  endtask

  task automatic test_single();
    out_rdy = 1'b1;
    set_pl(2, 8'hA5);
    arb_req = 5'b00100;
    #1;
    checks++; if (arb_gnt !== 5'b00100) begin errors++; $display("FAIL single_gnt: got %b want 00100", arb_gnt); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL single_vld_pre: got %b want 0", out_vld); end
    tick();
    arb_req = '0;
    #1;
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL single_vld: got %b want 1", out_vld); end
    checks++; if (payload_o !== 8'hA5) begin errors++; $display("FAIL single_payload: got %h want a5", payload_o); end
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", out_vld); end
    // rr_ptr is now 3, so input 3 must beat input 0
    set_pl(3, 8'h3C); set_pl(0, 8'h0C);
    arb_req = 5'b01001;
    #1;
    checks++; if (arb_gnt !== 5'b01000) begin errors++; $display("FAIL single_rr3: got %b want 01000", arb_gnt); end
    tick();
    arb_req = '0;
    #1;
    checks++; if (payload_o !== 8'h3C) begin errors++; $display("FAIL single_rr3_payload: got %h want 3c", payload_o); end
    tick();
  endtask

  task automatic test_fairness();
    pulse_reset();
    out_rdy = 1'b1;
    for (int i = 0; i < NP; i++) set_pl(i, 8'(8'h10 + i));
    arb_req = 5'b11111;
    for (int k = 0; k < NP; k++) begin
      #1;
      checks++; if (arb_gnt !== 5'(1 << k)) begin errors++; $display("FAIL fair_gnt%0d: got %b want %b", k, arb_gnt, 5'(1 << k)); end
      tick();
      arb_req[k] = 1'b0;
      #1;
      checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL fair_vld%0d: got %b want 1", k, out_vld); end
      checks++; if (payload_o !== 8'(8'h10 + k)) begin errors++; $display("FAIL fair_payload%0d: got %h want %h", k, payload_o, 8'(8'h10 + k)); end
    end
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL fair_drain: got %b want 0", out_vld); end
    arb_req = 5'b10001;
    #1;
    checks++; if (arb_gnt !== 5'b00001) begin errors++; $display("FAIL fair_rr_wrap: got %b want 00001", arb_gnt); end
    arb_req = '0;
    tick();
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    set_pl(0, 8'hB0); set_pl(1, 8'hB1); set_pl(2, 8'hB2);
    arb_req = 5'b00111;
    #1;
    checks++; if (arb_gnt !== 5'b00001) begin errors++; $display("FAIL bp_gnt0: got %b want 00001", arb_gnt); end
    tick();
    arb_req[0] = 1'b0;
    #1;
    checks++; if (arb_gnt !== 5'b00010) begin errors++; $display("FAIL bp_gnt1: got %b want 00010", arb_gnt); end
    checks++; if (payload_o !== 8'hB0) begin errors++; $display("FAIL bp_head0: got %h want b0", payload_o); end
    tick();
    arb_req[1] = 1'b0;
    #1;
    checks++; if (obuf_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_rdy: got %b want 0", obuf_rdy); end
    checks++; if (arb_gnt !== 5'b00000) begin errors++; $display("FAIL bp_full_gnt: got %b want 00000", arb_gnt); end
    tick();
    checks++; if (payload_o !== 8'hB0 || out_vld !== 1'b1) begin errors++; $display("FAIL bp_hold: got vld=%b %h want vld=1 b0", out_vld, payload_o); end
    out_rdy = 1'b1;
    #1;
    checks++; if (arb_gnt !== 5'b00000) begin errors++; $display("FAIL bp_full_pop_gnt: got %b want 00000", arb_gnt); end
    tick();
    checks++; if (obuf_rdy !== 1'b1) begin errors++; $display("FAIL bp_after_pop_rdy: got %b want 1", obuf_rdy); end
    checks++; if (arb_gnt !== 5'b00100) begin errors++; $display("FAIL bp_gnt2: got %b want 00100", arb_gnt); end
    checks++; if (payload_o !== 8'hB1) begin errors++; $display("FAIL bp_head1: got %h want b1", payload_o); end
    tick();
    arb_req[2] = 1'b0;
    #1;
    checks++; if (payload_o !== 8'hB2 || out_vld !== 1'b1) begin errors++; $display("FAIL bp_head2: got vld=%b %h want vld=1 b2", out_vld, payload_o); end
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_vld); end
  endtask

  task automatic test_reset_midstream();
    out_rdy = 1'b0;
    set_pl(0, 8'hC0); set_pl(1, 8'hC1); set_pl(4, 8'hC4);
    arb_req = 5'b00011;
    tick();
    arb_req[0] = 1'b0;
    tick();
    arb_req = '0;
    #1;
    checks++; if (out_vld !== 1'b1 || obuf_rdy !== 1'b0) begin errors++; $display("FAIL mid_full: got vld=%b rdy=%b want vld=1 rdy=0", out_vld, obuf_rdy); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_vld: got %b want 0", out_vld); end
    checks++; if (obuf_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_rdy: got %b want 1", obuf_rdy); end
    checks++; if (payload_o !== 8'h00) begin errors++; $display("FAIL mid_rst_payload: got %h want 00", payload_o); end
    tick();
    rst_n = 1'b1;
    arb_req = 5'b10001;
    #1;
    checks++; if (arb_gnt !== 5'b00001) begin errors++; $display("FAIL mid_rr_restart: got %b want 00001", arb_gnt); end
    tick();
    arb_req = '0;
    out_rdy = 1'b1;
    #1;
    checks++; if (payload_o !== 8'hC0 || out_vld !== 1'b1) begin errors++; $display("FAIL mid_first_pkt: got vld=%b %h want vld=1 c0", out_vld, payload_o); end
    tick();
  endtask

`ifdef OBUF_PERF_EN
  task automatic test_perf();
    pulse_reset();
    checks++; if (pkt_cnt !== 16'd0 || stall_cnt !== 16'd0) begin errors++; $display("FAIL perf_rst: got %0d/%0d want 0/0", pkt_cnt, stall_cnt); end
    out_rdy = 1'b0;
    arb_req = 5'b00011;
    tick();
    arb_req = 5'b00010;
    tick();
    arb_req = '0;
    tick(); tick(); tick();
    out_rdy = 1'b1;
    tick(); tick();
    arb_req = 5'b00100;
    tick();
    arb_req = '0;
    tick();
    checks++; if (pkt_cnt !== 16'd3) begin errors++; $display("FAIL perf_pkt: got %0d want 3", pkt_cnt); end
    checks++; if (stall_cnt !== 16'd4) begin errors++; $display("FAIL perf_stall: got %0d want 4", stall_cnt); end
    out_rdy = 1'b0;
    arb_req = 5'b00001;
    tick();
    arb_req = '0;
    dut.stall_cnt = 16'hFFFD;
    repeat (5) tick();
    checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL perf_sat: got %h want ffff", stall_cnt); end
    out_rdy = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_reset_midstream();
`ifdef OBUF_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/obuf_arb.md
Name: obuf_arb

Overview:
- Output-port stage of the mesh router; one instance per output direction (N, S, E, W, B).
- Sits directly downstream of the five per-input buffers. Each input buffer holds one packet and raises a request bit toward every output it targets.
- This block round-robin arbitrates those requests, returns a one-hot grant plus a ready, and captures the granted payload into a small FIFO.
- It drives the packet onto the outgoing link with a valid/ready handshake.

Parameters:
- PYLD_W, `PKT_W, payload width in bits.
- DEPTH, 2, output FIFO entries; legal range 2..8.
- NPORT, 5, number of input ports; fixed at 5; bit i follows `DIR_* index order.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- arb_req  input  NPORT  bit i: input buffer i requests this output.
- payload_i  input  NPORT*PYLD_W  slice i = bits [i*PYLD_W +: PYLD_W]; payload held by input buffer i.
- arb_gnt  output  NPORT  one-hot grant to input buffer i; all-zero when nothing is granted.
- obuf_rdy  output  1  this block can accept a packet this cycle; top level fans it out to all five input buffers.
- out_vld  output  1  payload_o is valid.
- out_rdy  input  1  downstream link accepts.
- payload_o  output  PYLD_W  head-of-FIFO payload.

Behaviour:
- Reset (async assert, sync release): FIFO count=0, rd/wr pointers=0, rr_ptr=0. Outputs: out_vld=0, payload_o=0, obuf_rdy=1, arb_gnt=0.
- obuf_rdy = (count != DEPTH). It is derived from registered count only. There is no combinational path from arb_req or out_rdy to obuf_rdy.
- Round-robin pick: scan indices rr_ptr, rr_ptr+1, ... mod 5. The first set arb_req bit wins.
- arb_gnt = pick & {NPORT{obuf_rdy}}. It is combinational from arb_req and registers. It is always one-hot or zero.
- Transfer: occurs in a cycle with |arb_gnt. On the same edge:
  - the granted payload_i slice is written at wr_ptr;
  - wr_ptr increments mod DEPTH;
  - rr_ptr becomes (granted index + 1) mod 5; 4 wraps to 0.
  - The upstream buffer clears its request on that same edge.
- No transfer: rr_ptr holds. This covers no request and obuf_rdy=0.
- Pop: on out_vld & out_rdy, rd_ptr increments mod DEPTH.
- out_vld = (count != 0). payload_o = entry at rd_ptr, registered storage.
- Latency: a packet granted in cycle N is visible on payload_o/out_vld in cycle N+1 when the FIFO was empty.
- Count update:
  - push only: +1;
  - pop only: -1;
  - push and pop together: unchanged.
- Full: push is blocked even if a pop occurs the same cycle. obuf_rdy reflects the registered full state, so throughput at full is one bubble; this is accepted.
- Empty with out_rdy=1: no pop, no pointer movement.
- payload_o and out_vld hold stable while out_vld & ~out_rdy.
- Multi-bit route requests from one input are independent per output. This block grants only its own bit.
- Reset mid-operation: all FIFO contents are discarded, outputs return to reset values immediately, and the arbiter restarts at rr_ptr=0.

Optional Feature:
- Macro OBUF_PERF_EN.
- Defined: adds outputs pkt_cnt[15:0] and stall_cnt[15:0]; both reset to 0.
  - pkt_cnt increments on each pop.
  - stall_cnt increments on each cycle with out_vld & ~out_rdy.
  - Both saturate at 16'hFFFF (no wrap).
- Undefined: the ports and counters do not exist. Functional behaviour is identical.

Test Plan:
- Idle after reset: arb_req=0 -> arb_gnt=0, obuf_rdy=1, out_vld=0.
- Single request: arb_req=5'b00100, slice 2=0xA5, out_rdy=1 -> arb_gnt=5'b00100 that cycle; next cycle out_vld=1, payload_o=0xA5; rr_ptr=3.
- Fairness: all five inputs request with held requests, each cleared on its own grant, out_rdy=1 -> grants in order 0,1,2,3,4 on consecutive cycles. Payloads exit in the same order, rr_ptr returns to 0.
- Backpressure: out_rdy=0, three inputs requesting, DEPTH=2 -> two grants, then obuf_rdy=0 and arb_gnt=0. Release out_rdy -> after one pop, obuf_rdy=1 next cycle and the third is granted. No loss or duplication.
- Reset mid-stream: FIFO holding 2 packets, assert rst_n low -> out_vld=0, obuf_rdy=1 immediately. After release, the first request from input 0 wins over input 4.
- OBUF_PERF_EN: 3 pops and 4 stall cycles -> pkt_cnt=3, stall_cnt=4. Preload near max and run 5 more stalls -> stall_cnt stays 16'hFFFF.
